// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over a 0rw1r1w 512x64 SRAM macro with a 2-entry output buffer.
// Define SRAM_FIFO_LEVEL_EN to add the registered occupancy port "level".
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_WMASKS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef SRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] level
`endif
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, addr1_q;
    logic [ADDR_WIDTH:0]   sram_cnt;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic [1:0]            obuf_cnt, occ;
    logic                  head, rd_inflight, push, pop, issue;
    always_comb begin
        in_ready    = (sram_cnt != (ADDR_WIDTH+1)'(DEPTH)) && !rst;
        push        = in_valid && in_ready;
        out_valid   = (obuf_cnt != 2'd0) && !rst;
        pop         = out_valid && out_ready;
        occ         = obuf_cnt + 2'(rd_inflight);
        issue       = !rst && (sram_cnt != '0) && (occ < (pop ? 2'd3 : 2'd2));
        sram_csb0   = !push;
        sram_wmask0 = '1;
        sram_addr0  = wr_ptr;
        sram_din0   = in_data;
        sram_csb1   = !issue;
        sram_addr1  = issue ? rd_ptr : addr1_q;
        out_data    = obuf[head];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            addr1_q     <= '0;
            sram_cnt    <= '0;
            obuf_cnt    <= '0;
            head        <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (issue) begin
                rd_ptr  <= rd_ptr + 1'b1;
                addr1_q <= rd_ptr;
            end
            if (pop) head <= !head;
            sram_cnt    <= sram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
            obuf_cnt    <= obuf_cnt + 2'(rd_inflight) - 2'(pop);
            rd_inflight <= issue;
        end
    end
    // Tail slot is head+obuf_cnt mod 2; the occupancy bound on issue keeps it free or being popped.
    always_ff @(posedge clk) begin
        if (!rst && rd_inflight) obuf[head ^ obuf_cnt[0]] <= sram_dout1;
    end
`ifdef SRAM_FIFO_LEVEL_EN
    always_ff @(posedge clk) begin
        if (rst) level <= '0;
        else level <= level + (ADDR_WIDTH+2)'(push) - (ADDR_WIDTH+2)'(pop);
    end
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: randomized scoreboard bench for sram_fifo_ctrl with a behavioural SRAM macro.
module tb_sram_fifo_ctrl;
    localparam int DW = 64;
    localparam int AW = 9;
    localparam int NM = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, out_valid, sram_csb0, sram_csb1;
    logic [DW-1:0] out_data, sram_din0, sram_dout1;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0, sram_addr1;
`ifdef SRAM_FIFO_LEVEL_EN
    logic [AW+1:0] level;
`endif
    int tests = 0, fails = 0, npop = 0;
    logic [DW-1:0] q [$];
    logic [DW-1:0] mem [1<<AW];

    always #5 clk = ~clk;

    sram_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
`ifdef SRAM_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    // Macro model: data only valid the cycle after a read; garbage otherwise exposes bad captures.
    always @(posedge clk) begin
        if (!sram_csb0) mem[sram_addr0] <= sram_din0;
        sram_dout1 <= !sram_csb1 ? mem[sram_addr1] : {$urandom, $urandom};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        in_valid = v;
        in_data = d;
        out_ready = r;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: samples just before each rising edge, independent of stimulus.
    initial begin
        logic [AW-1:0] wa, ra;
        logic prev_stall;
        logic [DW-1:0] prev_data;
        wa = '0; ra = '0; prev_stall = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                chk("rst_csb0", sram_csb0, 1);
                chk("rst_csb1", sram_csb1, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 0);
                q.delete();
                wa = '0; ra = '0; prev_stall = 1'b0;
            end else begin
`ifdef SRAM_FIFO_LEVEL_EN
                chk("level", level, q.size());
`endif
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, prev_data);
                end
                if (!sram_csb1) begin
                    chk("rd_addr", sram_addr1, ra);
                    ra++;
                end
                if (out_valid && out_ready) begin
                    npop++;
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL pop_extra: got %h expected no word", out_data);
                    end else chk("pop_data", out_data, q.pop_front());
                end
                if (in_valid && in_ready) begin
                    chk("wr_csb0", sram_csb0, 0);
                    chk("wr_wmask", sram_wmask0, 8'hFF);
                    chk("wr_addr", sram_addr0, wa);
                    chk("wr_din", sram_din0, in_data);
                    wa++;
                    q.push_back(in_data);
                end else chk("no_write", sram_csb0, 1);
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc, bubbles, base, mode;
        // First-word latency
        do_reset(2);
        cyc(1, 64'h0123456789ABCDEF, 1);
        #3;
        chk("lat_csb0", sram_csb0, 0);
        chk("lat_addr0", sram_addr0, 0);
        chk("lat_wmask", sram_wmask0, 8'hFF);
        lat = 0;
        while (lat < 20) begin
            cyc(0, 0, 1);
            #3;
            lat++;
            if (out_valid) break;
        end
        chk("first_latency", lat, 3);
        chk("first_data", out_data, 64'h0123456789ABCDEF);
        repeat (3) cyc(0, 0, 1);
        // Fill to full with consumer stalled, then drain
        do_reset(1);
        acc = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1, 64'(acc), 0);
            #3;
            if (in_ready) acc++;
        end
        chk("full_accepted", acc, 514);
        chk("full_in_ready", in_ready, 0);
        for (int i = 0; i < 600; i++) cyc(0, 0, 1);
        #3;
        chk("full_drained", q.size(), 0);
        // Continuous full-rate traffic with address wrap
        do_reset(1);
        bubbles = 0;
        for (int i = 0; i < 2004; i++) begin
            cyc(i < 2000, {$urandom, $urandom}, 1);
            #3;
            if (i >= 3 && i < 2003 && !out_valid) bubbles++;
        end
        chk("stream_bubbles", bubbles, 0);
        chk("stream_drained", q.size(), 0);
        // Bursty producer, random consumer
        do_reset(1);
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) mode = $urandom_range(0, 2);
            cyc(mode == 0 ? 1'b1 : mode == 1 ? ($urandom % 4 == 0) : 1'($urandom),
                {$urandom, $urandom}, ($urandom % 3) != 0);
        end
        for (int i = 0; i < 600; i++) cyc(0, 0, 1);
        #3;
        chk("random_drained", q.size(), 0);
        // Reset with stored words and a read in flight
        do_reset(1);
        for (int i = 0; i < 5; i++) cyc(1, 64'(100 + i), 0);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_csb1", sram_csb1, 1);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_csb0", sram_csb0, 1);
        chk("post_rst_csb1", sram_csb1, 1);
        base = npop;
        cyc(1, 64'hAA, 1);
        repeat (8) cyc(0, 0, 1);
        #3;
        chk("post_rst_pops", npop - base, 1);
        chk("post_rst_empty", q.size(), 0);
`ifdef SRAM_FIFO_LEVEL_EN
        do_reset(1);
        repeat (3) cyc(1, {$urandom, $urandom}, 0);
        repeat (4) cyc(0, 0, 0);
        #3;
        chk("level_three", level, 3);
        chk("level_head_valid", out_valid, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        #3;
        chk("level_two", level, 2);
        do_reset(1);
        #3;
        chk("level_reset", level, 0);
`endif
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
